// File: rtl/register_tree_kv_pkg.sv
// Shared types and helpers for the key/value register-tree heap.
// Holds FSM states, op kinds, default entry layout and tree geometry.
package register_tree_pkg;

  typedef enum logic [1:0] {
    IDLE,
    OP,
    CAS_EVEN,
    CAS_ODD
  } state_t;

  typedef enum logic {
    OP_WRITE,
    OP_POP
  } op_t;

  localparam int DEF_KEY_W = 16;
  localparam int DEF_VAL_W = 16;

  typedef struct packed {
    logic                 valid;
    logic [DEF_KEY_W-1:0] key;
    logic [DEF_VAL_W-1:0] val;
  } entry_t;

  function automatic int capacity(input int depth);
    return (1 << depth) - 1;
  endfunction

  function automatic int node_level(input int idx);
    int lvl;
    lvl = 0;
    for (int b = 1; b < 31; b++)
      if (((idx + 1) >> b) != 0) lvl = b;
    return lvl;
  endfunction

  function automatic logic [63:0] odd_level_mask(input int n);
    logic [63:0] m;
    m = '0;
    for (int i = 0; i < 64; i++)
      if (i < n) m[i] = (node_level(i) % 2) == 1;
    return m;
  endfunction

endpackage

// File: rtl/register_tree_kv_cmp.sv
// Three-way parent/left/right compare-swap for one heap node.
// Entries are packed {valid, key, val}; payload travels with key.
module kv_comparator #(
  parameter int KEY_WIDTH = 16,
  parameter int VAL_WIDTH = 16,
  parameter int MAX_FIRST = 1
) (
  input  logic [KEY_WIDTH+VAL_WIDTH:0] par_i,
  input  logic [KEY_WIDTH+VAL_WIDTH:0] lft_i,
  input  logic [KEY_WIDTH+VAL_WIDTH:0] rgt_i,
  output logic [KEY_WIDTH+VAL_WIDTH:0] par_o,
  output logic [KEY_WIDTH+VAL_WIDTH:0] lft_o,
  output logic [KEY_WIDTH+VAL_WIDTH:0] rgt_o
);

  localparam int VB = KEY_WIDTH + VAL_WIDTH;

  logic                r_wins;
  logic [VB:0]         win;

  // a strictly beats b; ties never win, so the incumbent stays
  function automatic logic beats(
    input logic [VB:0] a,
    input logic [VB:0] b
  );
    logic [KEY_WIDTH-1:0] ka;
    logic [KEY_WIDTH-1:0] kb;
    ka = a[VB-1:VAL_WIDTH];
    kb = b[VB-1:VAL_WIDTH];
    if (!a[VB]) return 1'b0;
    if (!b[VB]) return 1'b1;
    if (MAX_FIRST != 0) return ka > kb;
    return ka < kb;
  endfunction

  // pick the best child, swap it up only if it beats the parent
  always_comb begin
    par_o  = par_i;
    lft_o  = lft_i;
    rgt_o  = rgt_i;
    r_wins = beats(rgt_i, lft_i);
    win    = r_wins ? rgt_i : lft_i;
    if (beats(win, par_i)) begin
      par_o = win;
      if (r_wins) rgt_o = par_i;
      else        lft_o = par_i;
    end
  end

endmodule

// File: rtl/register_tree_kv.sv
// Register-array binary heap of {key, val} with ready-gated ops.
// Odd/even compare-swap phases settle the tree after each op.
module register_tree_kv
  import register_tree_pkg::*;
#(
  parameter int TREE_DEPTH = 3,
  parameter int KEY_WIDTH  = 16,
  parameter int VAL_WIDTH  = 16,
  parameter int MAX_FIRST  = 1
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  i_wrt,
  input  logic                  i_read,
  input  logic [KEY_WIDTH-1:0]  i_key,
  input  logic [VAL_WIDTH-1:0]  i_val,
  output logic                  o_ready,
  output logic                  o_valid,
  output logic [KEY_WIDTH-1:0]  o_key,
  output logic [VAL_WIDTH-1:0]  o_val,
  output logic [TREE_DEPTH-1:0] o_count,
  output logic                  o_full,
  output logic                  o_empty,
  output logic                  o_err
);

  localparam int CAP    = capacity(TREE_DEPTH);
  localparam int NINT   = CAP / 2;
  localparam int SETTLE = 2 * TREE_DEPTH;
  localparam int CW     = $clog2(SETTLE + 1);
  localparam int EW     = 1 + KEY_WIDTH + VAL_WIDTH;
  localparam logic [63:0] ODD_MASK = odd_level_mask(NINT);

  typedef struct packed {
    logic                 valid;
    logic [KEY_WIDTH-1:0] key;
    logic [VAL_WIDTH-1:0] val;
  } node_t;

  node_t                 nodes_q [CAP];
  node_t                 nodes_d [CAP];
  state_t                state_q, state_d;
  op_t                   op_q, op_d;
  logic [TREE_DEPTH-1:0] count_q, count_d;
  logic [TREE_DEPTH-1:0] idx_q, idx_d;
  logic [CW-1:0]         settle_q, settle_d;
  logic [KEY_WIDTH-1:0]  key_q, key_d;
  logic [VAL_WIDTH-1:0]  val_q, val_d;
  logic                  err_q, err_d;

  logic [EW-1:0] cp [NINT];
  logic [EW-1:0] cl [NINT];
  logic [EW-1:0] cr [NINT];

  logic req, reject, accept, full, empty, odd_ph;

  for (genvar g = 0; g < NINT; g++) begin : g_cmp
    kv_comparator #(
      .KEY_WIDTH (KEY_WIDTH),
      .VAL_WIDTH (VAL_WIDTH),
      .MAX_FIRST (MAX_FIRST)
    ) u_cmp (
      .par_i (nodes_q[g]),
      .lft_i (nodes_q[2*g+1]),
      .rgt_i (nodes_q[2*g+2]),
      .par_o (cp[g]),
      .lft_o (cl[g]),
      .rgt_o (cr[g])
    );
  end

  assign full    = count_q == TREE_DEPTH'(CAP);
  assign empty   = count_q == '0;
  assign o_ready = (settle_q == '0) && (state_q != OP);
  assign o_valid = o_ready && nodes_q[0].valid;
  assign o_key   = o_valid ? nodes_q[0].key : '0;
  assign o_val   = o_valid ? nodes_q[0].val : '0;
  assign o_count = count_q;
  assign o_full  = full;
  assign o_empty = empty;
  assign o_err   = err_q;

  // next state: op acceptance, pending tree update, CAS phases
  always_comb begin
    nodes_d  = nodes_q;
    state_d  = state_q;
    op_d     = op_q;
    count_d  = count_q;
    idx_d    = idx_q;
    key_d    = key_q;
    val_d    = val_q;
    settle_d = (settle_q != '0) ? settle_q - 1'b1 : '0;
    odd_ph   = state_q == CAS_ODD;
    req      = i_wrt | i_read;
    reject   = (i_wrt & ~i_read & full) |
               (~i_wrt & i_read & empty);
    accept   = o_ready & req & ~reject;
    err_d    = req & (~o_ready | reject);

    unique case (state_q)
      IDLE: state_d = CAS_EVEN;
      OP: begin
        state_d = CAS_EVEN;
        if (op_q == OP_WRITE) begin
          nodes_d[idx_q].valid = 1'b1;
          nodes_d[idx_q].key   = key_q;
          nodes_d[idx_q].val   = val_q;
        end else begin
          nodes_d[0]     = nodes_q[idx_q];
          nodes_d[idx_q] = '0;
        end
      end
      CAS_EVEN, CAS_ODD: begin
        state_d = odd_ph ? CAS_EVEN : CAS_ODD;
        for (int i = 0; i < NINT; i++) begin
          if (ODD_MASK[i] == odd_ph) begin
            nodes_d[i]     = node_t'(cp[i]);
            nodes_d[2*i+1] = node_t'(cl[i]);
            nodes_d[2*i+2] = node_t'(cr[i]);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (accept) begin
      state_d  = OP;
      settle_d = CW'(SETTLE);
      key_d    = i_key;
      val_d    = i_val;
      unique case (1'b1)
        i_wrt & i_read & ~empty: begin
          op_d  = OP_WRITE;
          idx_d = '0;
        end
        i_wrt & ~(i_read & ~empty): begin
          op_d    = OP_WRITE;
          idx_d   = count_q;
          count_d = count_q + 1'b1;
        end
        default: begin
          op_d    = OP_POP;
          idx_d   = count_q - 1'b1;
          count_d = count_q - 1'b1;
        end
      endcase
    end
  end

  // state registers with synchronous reset
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < CAP; i++) nodes_q[i] <= '0;
      state_q  <= IDLE;
      op_q     <= OP_WRITE;
      count_q  <= '0;
      idx_q    <= '0;
      settle_q <= '0;
      key_q    <= '0;
      val_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      nodes_q  <= nodes_d;
      state_q  <= state_d;
      op_q     <= op_d;
      count_q  <= count_d;
      idx_q    <= idx_d;
      settle_q <= settle_d;
      key_q    <= key_d;
      val_q    <= val_d;
      err_q    <= err_d;
    end
  end

endmodule

// File: tb/tb_register_tree_kv.sv
// Directed bench for register_tree_kv: max-first and min-first trees.
// Expected roots are queued at drive time and checked after settle.
module tb_register_tree_kv;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [1:0]  wrt = '0;
  logic [1:0]  rd  = '0;
  logic [15:0] ikey [2];
  logic [15:0] ival [2];
  logic [1:0]  rdy, vld, full, empty, err;
  logic [15:0] okey [2];
  logic [15:0] oval [2];
  logic [2:0]  ocnt [2];

  int n_asrt = 0;
  int n_fail = 0;

  typedef struct {
    logic [15:0] k;
    logic [15:0] v;
    logic [2:0]  c;
  } exp_t;

  exp_t sbq[$];

  always #5 CLK = ~CLK;

  register_tree_kv #(
    .TREE_DEPTH (3),
    .KEY_WIDTH  (16),
    .VAL_WIDTH  (16),
    .MAX_FIRST  (1)
  ) u_max (
    .CLK     (CLK),
    .RST     (RST),
    .i_wrt   (wrt[1]),
    .i_read  (rd[1]),
    .i_key   (ikey[1]),
    .i_val   (ival[1]),
    .o_ready (rdy[1]),
    .o_valid (vld[1]),
    .o_key   (okey[1]),
    .o_val   (oval[1]),
    .o_count (ocnt[1]),
    .o_full  (full[1]),
    .o_empty (empty[1]),
    .o_err   (err[1])
  );

  register_tree_kv #(
    .TREE_DEPTH (3),
    .KEY_WIDTH  (16),
    .VAL_WIDTH  (16),
    .MAX_FIRST  (0)
  ) u_min (
    .CLK     (CLK),
    .RST     (RST),
    .i_wrt   (wrt[0]),
    .i_read  (rd[0]),
    .i_key   (ikey[0]),
    .i_val   (ival[0]),
    .o_ready (rdy[0]),
    .o_valid (vld[0]),
    .o_key   (okey[0]),
    .o_val   (oval[0]),
    .o_count (ocnt[0]),
    .o_full  (full[0]),
    .o_empty (empty[0]),
    .o_err   (err[0])
  );

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset(input int s);
    chk("rst_ready", 32'(rdy[s]), 32'd1);
    chk("rst_valid", 32'(vld[s]), 32'd0);
    chk("rst_key",   32'(okey[s]), 32'd0);
    chk("rst_val",   32'(oval[s]), 32'd0);
    chk("rst_count", 32'(ocnt[s]), 32'd0);
    chk("rst_empty", 32'(empty[s]), 32'd1);
    chk("rst_full",  32'(full[s]), 32'd0);
    chk("rst_err",   32'(err[s]), 32'd0);
  endtask

  task automatic settle_check(input int s);
    exp_t e;
    if (sbq.size() == 0) begin
      chk("sb_empty", 32'd0, 32'd1);
      return;
    end
    e = sbq.pop_front();
    chk("root_key", 32'(okey[s]), 32'(e.k));
    chk("root_val", 32'(oval[s]), 32'(e.v));
    chk("count",    32'(ocnt[s]), 32'(e.c));
    chk("valid",    32'(vld[s]), 32'(e.c != 0));
    chk("empty",    32'(empty[s]), 32'(e.c == 0));
    chk("full",     32'(full[s]), 32'(e.c == 7));
    chk("no_err",   32'(err[s]), 32'd0);
  endtask

  task automatic wait_ready(input int s, input int n0);
    int n;
    n = n0;
    while (!rdy[s] && n < 40) begin
      @(negedge CLK);
      n++;
    end
    chk("latency", n, 32'd7);
  endtask

  task automatic op(
    input int          s,
    input logic        w,
    input logic        r,
    input logic [15:0] k,
    input logic [15:0] v,
    input logic [15:0] ek,
    input logic [15:0] ev,
    input logic [2:0]  ec
  );
    exp_t e;
    @(negedge CLK);
    wrt[s]  = w;
    rd[s]   = r;
    ikey[s] = k;
    ival[s] = v;
    e.k = ek;
    e.v = ev;
    e.c = ec;
    sbq.push_back(e);
    @(negedge CLK);
    wrt[s] = 1'b0;
    rd[s]  = 1'b0;
    chk("count_t1", 32'(ocnt[s]), 32'(ec));
    chk("busy_t1",  32'(rdy[s]), 32'd0);
    wait_ready(s, 1);
    settle_check(s);
  endtask

  task automatic rej(
    input int          s,
    input logic        w,
    input logic        r,
    input logic [15:0] k,
    input logic [2:0]  ec
  );
    @(negedge CLK);
    wrt[s]  = w;
    rd[s]   = r;
    ikey[s] = k;
    ival[s] = 16'hEE;
    @(negedge CLK);
    wrt[s] = 1'b0;
    rd[s]  = 1'b0;
    chk("rej_err",   32'(err[s]), 32'd1);
    chk("rej_count", 32'(ocnt[s]), 32'(ec));
    chk("rej_ready", 32'(rdy[s]), 32'd1);
    @(negedge CLK);
    chk("rej_pulse", 32'(err[s]), 32'd0);
  endtask

  initial begin
    exp_t e;
    for (int i = 0; i < 2; i++) begin
      ikey[i] = '0;
      ival[i] = '0;
    end
    repeat (3) @(negedge CLK);
    chk_reset(1);
    chk_reset(0);
    RST = 1'b0;

    op(1, 1, 0, 16'd5, 16'hA, 16'd5, 16'hA, 3'd1);
    op(1, 1, 0, 16'd0, 16'hB, 16'd5, 16'hA, 3'd2);
    op(1, 1, 0, 16'd9, 16'hC, 16'd9, 16'hC, 3'd3);
    op(1, 1, 0, 16'd3, 16'hD, 16'd9, 16'hC, 3'd4);

    op(1, 0, 1, 16'd0, 16'd0, 16'd5, 16'hA, 3'd3);
    op(1, 0, 1, 16'd0, 16'd0, 16'd3, 16'hD, 3'd2);
    op(1, 0, 1, 16'd0, 16'd0, 16'd0, 16'hB, 3'd1);
    op(1, 0, 1, 16'd0, 16'd0, 16'd0, 16'h0, 3'd0);
    rej(1, 0, 1, 16'd0, 3'd0);

    for (int k = 1; k <= 7; k++)
      op(1, 1, 0, 16'(k), 16'(16'h10 + k),
         16'(k), 16'(16'h10 + k), 3'(k));
    rej(1, 1, 0, 16'd8, 3'd7);
    chk("full_root", 32'(okey[1]), 32'd7);
    op(1, 1, 1, 16'd0, 16'h99, 16'd6, 16'h16, 3'd7);

    @(negedge CLK);
    rd[1] = 1'b1;
    e.k = 16'd5;
    e.v = 16'h15;
    e.c = 3'd6;
    sbq.push_back(e);
    @(negedge CLK);
    rd[1]   = 1'b0;
    wrt[1]  = 1'b1;
    ikey[1] = 16'd9;
    chk("gate_busy", 32'(rdy[1]), 32'd0);
    @(negedge CLK);
    wrt[1] = 1'b0;
    chk("gate_err",   32'(err[1]), 32'd1);
    chk("gate_count", 32'(ocnt[1]), 32'd6);
    wait_ready(1, 2);
    settle_check(1);

    @(negedge CLK);
    wrt[1]  = 1'b1;
    ikey[1] = 16'd3;
    @(negedge CLK);
    wrt[1] = 1'b0;
    RST    = 1'b1;
    chk("pre_rst_busy", 32'(rdy[1]), 32'd0);
    @(negedge CLK);
    chk_reset(1);
    RST = 1'b0;
    op(1, 1, 0, 16'd2, 16'h22, 16'd2, 16'h22, 3'd1);

    op(0, 1, 1, 16'd8, 16'h80, 16'd8, 16'h80, 3'd1);
    op(0, 0, 1, 16'd0, 16'h0,  16'd0, 16'h0,  3'd0);
    op(0, 1, 0, 16'd4, 16'h1,  16'd4, 16'h1,  3'd1);
    op(0, 1, 0, 16'd4, 16'h2,  16'd4, 16'h1,  3'd2);
    op(0, 1, 0, 16'd2, 16'h3,  16'd2, 16'h3,  3'd3);
    op(0, 0, 1, 16'd0, 16'h0,  16'd4, 16'h1,  3'd2);
    op(0, 0, 1, 16'd0, 16'h0,  16'd4, 16'h2,  3'd1);
    op(0, 0, 1, 16'd0, 16'h0,  16'd0, 16'h0,  3'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_asrt, n_fail);
    $finish;
  end

endmodule
